ha_stim_checker: RTL and testbench



---
 rtl/ha_stim_checker_if.sv | 24 ++
 rtl/ha_stim_checker.sv | 102 ++++++++++
 tb/tb_ha_stim_checker.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ha_stim_checker_if.sv
// ha_stim_checker_if: stimulus/response bundle between the checker and its half-adder environment
// master: the checker (drives stimulus and status, observes sum_in/carry_in)
// slave:  the environment (drives start and the half-adder outputs, observes the rest)
interface ha_stim_checker_if;
  logic       start;
  logic       sum_in;
  logic       carry_in;
  logic       a_out;
  logic       b_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  logic [1:0] first_fail_vec;
  logic       first_fail_valid;
  modport master (
    input  start, sum_in, carry_in,
    output a_out, b_out, busy, done, pass, err_count, first_fail_vec, first_fail_valid
  );
  modport slave (
    output start, sum_in, carry_in,
    input  a_out, b_out, busy, done, pass, err_count, first_fail_vec, first_fail_valid
  );
endinterface

// File: rtl/ha_stim_checker.sv
// ha_stim_checker: on-chip stimulus/response checker sweeping a half adder through 00,10,01,11
// Ports: clk, rst (sync, active-high); bus (ha_stim_checker_if.master) carries start,
//   sum_in/carry_in from the half adder, a_out/b_out stimulus and busy/done/pass/err_count/first_fail_* status.
// Params: SETTLE_CYCLES (0..15) wait before sampling, PASSES (1..255) full sweeps per run.
// Macro HA_CHK_STOP_ON_FAIL_EN: when defined, the first mismatch ends the run.
module ha_stim_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1
) (
  input logic               clk,
  input logic               rst,
  ha_stim_checker_if.master bus
);
  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;
  state_t     state_q;
  logic [1:0] idx_q;
  logic [7:0] pass_cnt_q;
  logic [3:0] cnt_q;
  logic       a_q, b_q, busy_q, done_q, pass_q, ffvalid_q;
  logic [7:0] err_q;
  logic [1:0] ffv_q;
  logic       mism, last, stop;
  logic [7:0] err_d;
  logic [1:0] idx_d;
  assign mism  = (bus.sum_in != (a_q ^ b_q)) || (bus.carry_in != (a_q & b_q));
  assign err_d = (mism && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  assign last  = (idx_q == 2'd3) && (pass_cnt_q >= 8'(PASSES - 1));
  assign idx_d = idx_q + 2'd1;
`ifdef HA_CHK_STOP_ON_FAIL_EN
  assign stop = mism;
`else
  assign stop = 1'b0;
`endif
  // vector index i maps to {a,b} = {i[0],i[1]}, giving the order 00,10,01,11
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      pass_cnt_q <= '0;
      cnt_q      <= '0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      ffv_q      <= '0;
      ffvalid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: if (bus.start) begin
          state_q    <= DRIVE;
          idx_q      <= '0;
          pass_cnt_q <= '0;
          a_q        <= 1'b0;
          b_q        <= 1'b0;
          busy_q     <= 1'b1;
          done_q     <= 1'b0;
          pass_q     <= 1'b0;
          err_q      <= '0;
          ffv_q      <= '0;
          ffvalid_q  <= 1'b0;
        end
        DRIVE: begin
          cnt_q   <= '0;
          state_q <= (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
        end
        SETTLE: if (cnt_q == 4'(SETTLE_CYCLES - 1)) state_q <= CHECK;
                else cnt_q <= cnt_q + 4'd1;
        CHECK: begin
          err_q <= err_d;
          if (mism && !ffvalid_q) begin
            ffv_q     <= {a_q, b_q};
            ffvalid_q <= 1'b1;
          end
          if (stop || last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == 8'd0);
          end else begin
            // idx wraps 3->0 when a new sweep begins
            state_q <= DRIVE;
            idx_q   <= idx_d;
            a_q     <= idx_d[0];
            b_q     <= idx_d[1];
            if (idx_q == 2'd3) pass_cnt_q <= pass_cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.a_out            = a_q;
  assign bus.b_out            = b_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.pass             = pass_q;
  assign bus.err_count        = err_q;
  assign bus.first_fail_vec   = ffv_q;
  assign bus.first_fail_valid = ffvalid_q;
endmodule

// File: tb/tb_ha_stim_checker.sv
// tb_ha_stim_checker: directed-vector bench for ha_stim_checker against good and faulty half-adder models
module tb_ha_stim_checker;
`ifdef HA_CHK_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rs [3];
  logic st [3];
  logic done_w [3];
  int   fm0;
  int   n_vec = 0;
  int   n_miss = 0;
  int   ab_log [0:20];
  int   bz_log [0:20];
  int   de;
  ha_stim_checker_if if0 ();
  ha_stim_checker_if if1 ();
  ha_stim_checker_if if2 ();
  // fm0: 0 good half adder, 1 carry stuck at 0, 2 sum inverted
  assign if0.start    = st[0];
  assign if0.sum_in   = (if0.a_out ^ if0.b_out) ^ (fm0 == 2);
  assign if0.carry_in = (if0.a_out & if0.b_out) & (fm0 != 1);
  assign if1.start    = st[1];
  assign if1.sum_in   = ~(if1.a_out ^ if1.b_out);
  assign if1.carry_in = if1.a_out & if1.b_out;
  assign if2.start    = st[2];
  assign if2.sum_in   = ~(if2.a_out ^ if2.b_out);
  assign if2.carry_in = if2.a_out & if2.b_out;
  assign done_w[0] = if0.done;
  assign done_w[1] = if1.done;
  assign done_w[2] = if2.done;
  ha_stim_checker u0 (.clk(clk), .rst(rs[0]), .bus(if0));
  ha_stim_checker #(.PASSES(3)) u1 (.clk(clk), .rst(rs[1]), .bus(if1));
  ha_stim_checker #(.SETTLE_CYCLES(0), .PASSES(70)) u2 (.clk(clk), .rst(rs[2]), .bus(if2));
  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // start is sampled at edge 0; de = first edge n after it with done high (-1 if none within limit)
  task automatic run(input int k, input int rep, input int rse, input int limit, output int d);
    d = -1;
    st[k] = 1'b1;
    @(posedge clk);
    #1 st[k] = 1'b0;
    for (int n = 1; n <= limit; n++) begin
      if (n == rep) st[k] = 1'b1;
      if (n == rse) rs[k] = 1'b1;
      @(posedge clk);
      #1;
      st[k] = 1'b0;
      rs[k] = 1'b0;
      if (k == 0 && n <= 20) begin
        ab_log[n] = {30'd0, if0.a_out, if0.b_out};
        bz_log[n] = int'(if0.busy);
      end
      if (done_w[k] && d < 0) d = n;
      if (n == rse) break;
    end
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_a"}, int'(if0.a_out), 0);
    check({tag, "_b"}, int'(if0.b_out), 0);
    check({tag, "_busy"}, int'(if0.busy), 0);
    check({tag, "_done"}, int'(if0.done), 0);
    check({tag, "_pass"}, int'(if0.pass), 0);
    check({tag, "_err"}, int'(if0.err_count), 0);
    check({tag, "_ffv"}, int'(if0.first_fail_vec), 0);
    check({tag, "_ffvalid"}, int'(if0.first_fail_valid), 0);
  endtask
  initial begin
    int order [4];
    order = '{0, 2, 1, 3};
    fm0 = 0;
    for (int i = 0; i < 3; i++) begin
      rs[i] = 1'b1;
      st[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) rs[i] = 1'b0;
    check_zero("reset");
    run(0, 0, 0, 20, de);
    check("ok_done_edge", de, 16);
    check("ok_pass", int'(if0.pass), 1);
    check("ok_err", int'(if0.err_count), 0);
    check("ok_ffvalid", int'(if0.first_fail_valid), 0);
    check("ok_busy_end", int'(if0.busy), 0);
    check("ok_busy_run", bz_log[1], 1);
    for (int v = 0; v < 4; v++) begin
      check("ok_ab_first", ab_log[4*v+1], order[v]);
      check("ok_ab_last", ab_log[4*v+3], order[v]);
    end
    check("ok_ab_hold", ab_log[20], 3);
    fm0 = 1;
    run(0, 0, 0, 20, de);
    check("cs0_done_edge", de, 16);
    check("cs0_err", int'(if0.err_count), 1);
    check("cs0_ffv", int'(if0.first_fail_vec), 3);
    check("cs0_ffvalid", int'(if0.first_fail_valid), 1);
    check("cs0_pass", int'(if0.pass), 0);
    fm0 = 0;
    run(0, 5, 0, 20, de);
    check("repulse_done_edge", de, 16);
    check("repulse_pass", int'(if0.pass), 1);
    check("repulse_err", int'(if0.err_count), 0);
    fm0 = 2;
    run(0, 0, 9, 20, de);
    check_zero("midrst");
    fm0 = 0;
    run(0, 0, 0, 20, de);
    check("after_rst_done_edge", de, 16);
    check("after_rst_pass", int'(if0.pass), 1);
    fm0 = 2;
    run(0, 0, 0, 20, de);
    check("inv_done_edge", de, STOP ? 4 : 16);
    check("inv_err", int'(if0.err_count), STOP ? 1 : 4);
    check("inv_ffv", int'(if0.first_fail_vec), 0);
    check("inv_ffvalid", int'(if0.first_fail_valid), 1);
    check("inv_pass", int'(if0.pass), 0);
    run(1, 0, 0, 52, de);
    check("p3_done_edge", de, STOP ? 4 : 48);
    check("p3_err", int'(if1.err_count), STOP ? 1 : 12);
    check("p3_ffv", int'(if1.first_fail_vec), 0);
    check("p3_pass", int'(if1.pass), 0);
    run(2, 0, 0, 565, de);
    check("p70_done_edge", de, STOP ? 2 : 560);
    check("p70_err", int'(if2.err_count), STOP ? 1 : 255);
    check("p70_ffv", int'(if2.first_fail_vec), 0);
    check("p70_pass", int'(if2.pass), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
